// File: rtl/mem_arb_pkg.sv
// Shared types for the memory-port arbiter: FSM states and requester identity.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RESP
    } state_e;

    typedef enum logic {
        SRC_IC,
        SRC_DC
    } src_e;

endpackage

// File: rtl/mem_port_arbiter.sv
// Shares one backing-memory word port between icache refills and the dcache MSHR,
// one transaction at a time, round-robin with an MSHR-full override and a watchdog.
//
// state | meaning
// IDLE  | evaluate requests, grant at most one, latch its payload
// BUSY  | mem_req held until mem_ack or watchdog expiry
// RESP  | one-cycle done pulse to the owning requester, update fairness
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ic_valid,
    input  logic [ADDR_W-1:0] ic_addr,
    output logic              ic_gnt,
    output logic              ic_done,
    input  logic              dc_valid,
    input  logic              dc_we,
    input  logic [ADDR_W-1:0] dc_addr,
    input  logic [DATA_W-1:0] dc_wdata,
    input  logic              dc_urgent,
    output logic              dc_gnt,
    output logic              dc_done,
    output logic [DATA_W-1:0] rdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              timeout_err
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    // Counter holds completed BUSY cycles, so this value marks the last allowed one.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_e            state;
    state_e            state_nxt;
    src_e              last_grant;
    src_e              src_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              we_q;
    logic [DATA_W-1:0] rdata_q;
    logic [CNT_W-1:0]  cnt;
    logic              err_q;
    logic              dc_wins;
    logic              expired;

    assign expired = (cnt == CNT_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        ic_gnt    = 1'b0;
        dc_gnt    = 1'b0;
        dc_wins   = 1'b0;
        case (state)
            IDLE: begin
                if (ic_valid && dc_valid) begin
                    dc_wins = dc_urgent || (last_grant == SRC_IC);
                end else begin
                    dc_wins = dc_valid;
                end
                dc_gnt = dc_valid && dc_wins;
                ic_gnt = ic_valid && !dc_wins;
                if (ic_gnt || dc_gnt) begin
                    state_nxt = BUSY;
                end
            end
            BUSY: begin
                if (mem_ack || expired) begin
                    state_nxt = RESP;
                end
            end
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant <= SRC_DC;
            src_q      <= SRC_IC;
            addr_q     <= '0;
            wdata_q    <= '0;
            we_q       <= 1'b0;
            rdata_q    <= '0;
            cnt        <= '0;
            err_q      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (dc_gnt) begin
                        src_q   <= SRC_DC;
                        addr_q  <= dc_addr;
                        wdata_q <= dc_we ? dc_wdata : '0;
                        we_q    <= dc_we;
                    end else if (ic_gnt) begin
                        src_q   <= SRC_IC;
                        addr_q  <= ic_addr;
                        wdata_q <= '0;
                        we_q    <= 1'b0;
                    end
                end
                BUSY: begin
                    cnt <= cnt + CNT_W'(1);
                    // An ack on the final watchdog cycle is still a normal completion.
                    if (mem_ack) begin
                        rdata_q <= we_q ? '0 : mem_rdata;
                    end else if (expired) begin
                        rdata_q <= '0;
                        err_q   <= 1'b1;
                    end
                end
                RESP: begin
                    last_grant <= src_q;
                    cnt        <= '0;
                end
                default: ;
            endcase
        end
    end

    assign mem_req     = (state == BUSY);
    assign mem_we      = mem_req && we_q;
    assign mem_addr    = addr_q;
    assign mem_wdata   = wdata_q;
    assign rdata       = rdata_q;
    assign ic_done     = (state == RESP) && (src_q == SRC_IC);
    assign dc_done     = (state == RESP) && (src_q == SRC_DC);
    assign timeout_err = err_q;

endmodule
